// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'd0;
    localparam fwd_sel_t FWD_EXMEM = 2'd1;
    localparam fwd_sel_t FWD_WB    = 2'd2;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;

    // x0 is hardwired to zero, so it never carries a dependency.
    function automatic logic hz_match(input logic       wr,
                                      input logic [4:0] dest,
                                      input logic [4:0] src,
                                      input logic       used);
        return wr && (dest != 5'd0) && (dest == src) && used;
    endfunction

    // A load still in MEM has no data yet, so only the WB copy can bypass it.
    function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                            input logic       mem_wr,
                                            input logic [4:0] mem_dest,
                                            input logic       mem_ld,
                                            input logic       wb_wr,
                                            input logic [4:0] wb_dest);
        if (hz_match(mem_wr, mem_dest, src, 1'b1) && !mem_ld)
            return FWD_EXMEM;
        else if (hz_match(wb_wr, wb_dest, src, 1'b1))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_dmem_wait_fsm.sv
// Data-memory wait tracker: IDLE/WAIT FSM, frozen-cycle counter and sticky timeout flag.
module dmem_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_freeze,
    output logic o_err,
    output logic o_state
);

    localparam int WAIT_W = (DMEM_TIMEOUT < 1) ? 1 : $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(DMEM_TIMEOUT);

    dmem_state_t       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic [WAIT_W-1:0] w_cnt_inc;

    // Saturate so a very long wait cannot roll the counter back under the limit.
    assign w_cnt_inc = (r_wait_cnt == TMO) ? r_wait_cnt : r_wait_cnt + 1'b1;

    assign o_freeze = ((r_state == IDLE) && i_req && !i_ready) ||
                      ((r_state == WAIT) && !i_ready);
    assign o_err    = r_err;
    assign o_state  = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req && !i_ready) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TMO) r_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_ready) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TMO) r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, stall and flush controller for the 5-stage pipeline.
// Define PIPELINE_FORWARDING_EN to enable operand forwarding (load-use stalls only).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_idx,
    input  logic [4:0]       id_rs2_idx,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_ex_rs1_idx,
    input  logic [4:0]       id_ex_rs2_idx,
    input  logic [4:0]       id_ex_dest_reg_idx,
    input  logic             id_ex_reg_wr,
    input  logic             id_ex_rd_mem,
    input  logic [4:0]       ex_mem_dest_reg_idx,
    input  logic             ex_mem_reg_wr,
    input  logic             ex_mem_rd_mem,
    input  logic             ex_mem_wr_mem,
    input  logic [4:0]       mem_wb_dest_reg_idx,
    input  logic             mem_wb_reg_wr,
    input  logic             ex_mem_take_branch,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             dmem_err,
    output logic             dbg_dmem_state
);

    logic             w_freeze;
    logic             w_hz;
    logic             w_stall_evt;
    logic             w_flush_evt;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    dmem_wait_fsm #(
        .DMEM_TIMEOUT(DMEM_TIMEOUT)
    ) u_dmem_wait (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (ex_mem_rd_mem | ex_mem_wr_mem),
        .i_ready (dmem_ready),
        .o_freeze(w_freeze),
        .o_err   (dmem_err),
        .o_state (dbg_dmem_state)
    );

`ifdef PIPELINE_FORWARDING_EN
    assign w_hz = id_ex_rd_mem &&
                  (hz_match(id_ex_reg_wr, id_ex_dest_reg_idx, id_rs1_idx, id_rs1_used) ||
                   hz_match(id_ex_reg_wr, id_ex_dest_reg_idx, id_rs2_idx, id_rs2_used));
    assign w_fwd_a = fwd_select(id_ex_rs1_idx, ex_mem_reg_wr, ex_mem_dest_reg_idx,
                                ex_mem_rd_mem, mem_wb_reg_wr, mem_wb_dest_reg_idx);
    assign w_fwd_b = fwd_select(id_ex_rs2_idx, ex_mem_reg_wr, ex_mem_dest_reg_idx,
                                ex_mem_rd_mem, mem_wb_reg_wr, mem_wb_dest_reg_idx);
`else
    // The register file does not bypass, so any in-flight writer of a used source stalls ID.
    assign w_hz = hz_match(id_ex_reg_wr,  id_ex_dest_reg_idx,  id_rs1_idx, id_rs1_used) ||
                  hz_match(id_ex_reg_wr,  id_ex_dest_reg_idx,  id_rs2_idx, id_rs2_used) ||
                  hz_match(ex_mem_reg_wr, ex_mem_dest_reg_idx, id_rs1_idx, id_rs1_used) ||
                  hz_match(ex_mem_reg_wr, ex_mem_dest_reg_idx, id_rs2_idx, id_rs2_used) ||
                  hz_match(mem_wb_reg_wr, mem_wb_dest_reg_idx, id_rs1_idx, id_rs1_used) ||
                  hz_match(mem_wb_reg_wr, mem_wb_dest_reg_idx, id_rs2_idx, id_rs2_used);
    assign w_fwd_a = FWD_REG;
    assign w_fwd_b = FWD_REG;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{id_ex_rs1_idx, id_ex_rs2_idx, id_ex_rd_mem};
`endif

    // Freeze wins over a branch; a branch wins over a hazard since the stalled instruction dies.
    assign w_flush_evt = !w_freeze && ex_mem_take_branch;
    assign w_stall_evt = w_freeze || (w_hz && !ex_mem_take_branch);

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        fwd_a_sel     = w_fwd_a;
        fwd_b_sel     = w_fwd_b;
        if (!rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            fwd_a_sel     = FWD_REG;
            fwd_b_sel     = FWD_REG;
        end else if (w_freeze) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (ex_mem_take_branch) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_hz) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_evt) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_flush_evt) r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; follows PIPELINE_FORWARDING_EN when defined.
module tb_pipeline_ctrl;

`ifdef PIPELINE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_W = 16;

  localparam logic [4:0] EN_RUN   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b00111;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [2:0] FL_NONE  = 3'b000;
  localparam logic [2:0] FL_STALL = 3'b010;
  localparam logic [2:0] FL_ALL   = 3'b111;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_idx, id_rs2_idx, id_ex_rs1_idx, id_ex_rs2_idx;
  logic id_rs1_used, id_rs2_used;
  logic [4:0] id_ex_dest_reg_idx, ex_mem_dest_reg_idx, mem_wb_dest_reg_idx;
  logic id_ex_reg_wr, id_ex_rd_mem, ex_mem_reg_wr, ex_mem_rd_mem, ex_mem_wr_mem;
  logic mem_wb_reg_wr, ex_mem_take_branch, dmem_ready;
  logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic dmem_err, dbg_dmem_state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_ex_rs1_idx(id_ex_rs1_idx), .id_ex_rs2_idx(id_ex_rs2_idx),
    .id_ex_dest_reg_idx(id_ex_dest_reg_idx), .id_ex_reg_wr(id_ex_reg_wr), .id_ex_rd_mem(id_ex_rd_mem),
    .ex_mem_dest_reg_idx(ex_mem_dest_reg_idx), .ex_mem_reg_wr(ex_mem_reg_wr),
    .ex_mem_rd_mem(ex_mem_rd_mem), .ex_mem_wr_mem(ex_mem_wr_mem),
    .mem_wb_dest_reg_idx(mem_wb_dest_reg_idx), .mem_wb_reg_wr(mem_wb_reg_wr),
    .ex_mem_take_branch(ex_mem_take_branch), .dmem_ready(dmem_ready),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles), .flush_events(flush_events),
    .dmem_err(dmem_err), .dbg_dmem_state(dbg_dmem_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_dest;
    logic       ex_wr, ex_ld;
    logic [4:0] mem_dest;
    logic       mem_wr, mem_ld;
    logic [4:0] wb_dest;
    logic       wb_wr, br;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2,
                              input logic [4:0] ex_rs1, input logic [4:0] ex_rs2,
                              input logic [4:0] ex_dest, input logic ex_wr, input logic ex_ld,
                              input logic [4:0] mem_dest, input logic mem_wr, input logic mem_ld,
                              input logic [4:0] wb_dest, input logic wb_wr, input logic br,
                              input logic [4:0] exp_en, input logic [2:0] exp_fl,
                              input logic [1:0] exp_fa, input logic [1:0] exp_fb);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.ex_rs1 = ex_rs1; v.ex_rs2 = ex_rs2; v.ex_dest = ex_dest; v.ex_wr = ex_wr; v.ex_ld = ex_ld;
    v.mem_dest = mem_dest; v.mem_wr = mem_wr; v.mem_ld = mem_ld;
    v.wb_dest = wb_dest; v.wb_wr = wb_wr; v.br = br;
    v.exp_en = exp_en; v.exp_fl = exp_fl; v.exp_fa = exp_fa; v.exp_fb = exp_fb;
    return v;
  endfunction

  // driver tasks
  task automatic quiet();
    id_rs1_idx = 0; id_rs2_idx = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_ex_rs1_idx = 0; id_ex_rs2_idx = 0;
    id_ex_dest_reg_idx = 0; id_ex_reg_wr = 0; id_ex_rd_mem = 0;
    ex_mem_dest_reg_idx = 0; ex_mem_reg_wr = 0; ex_mem_rd_mem = 0; ex_mem_wr_mem = 0;
    mem_wb_dest_reg_idx = 0; mem_wb_reg_wr = 0;
    ex_mem_take_branch = 0; dmem_ready = 1;
  endtask

  task automatic apply(input vec_t v);
    quiet();
    id_rs1_idx = v.rs1; id_rs2_idx = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    id_ex_rs1_idx = v.ex_rs1; id_ex_rs2_idx = v.ex_rs2;
    id_ex_dest_reg_idx = v.ex_dest; id_ex_reg_wr = v.ex_wr; id_ex_rd_mem = v.ex_ld;
    ex_mem_dest_reg_idx = v.mem_dest; ex_mem_reg_wr = v.mem_wr; ex_mem_rd_mem = v.mem_ld;
    mem_wb_dest_reg_idx = v.wb_dest; mem_wb_reg_wr = v.wb_wr;
    ex_mem_take_branch = v.br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    quiet();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] e_en, input logic [2:0] e_fl,
                         input logic [1:0] e_fa, input logic [1:0] e_fb);
    chk({tag, " enables"}, 32'({pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable}), 32'(e_en));
    chk({tag, " flushes"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e_fl));
    chk({tag, " fwd_a"}, 32'(fwd_a_sel), 32'(e_fa));
    chk({tag, " fwd_b"}, 32'(fwd_b_sel), 32'(e_fb));
  endtask

  task automatic chk_cnt(input string tag, input int e_stall, input int e_flush, input logic e_err);
    chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'(e_stall));
    chk({tag, " flush_events"}, 32'(flush_events), 32'(e_flush));
    chk({tag, " dmem_err"}, 32'(dmem_err), 32'(e_err));
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_RUN, FL_NONE, 0, 0);
    vecs[1]  = mk(5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0,
                  FWD ? EN_RUN : EN_STALL, FWD ? FL_NONE : FL_STALL, 0, 0);
    vecs[2]  = mk(1, 5, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, EN_STALL, FL_STALL, 0, 0);
    vecs[3]  = mk(5, 5, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, EN_RUN, FL_NONE, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, EN_RUN, FL_NONE, 0, 0);
    vecs[5]  = mk(3, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0,
                  FWD ? EN_RUN : EN_STALL, FWD ? FL_NONE : FL_STALL, 0, 0);
    vecs[6]  = mk(1, 2, 1, 1, 9, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, EN_RUN, FL_NONE, FWD ? 2'd1 : 2'd0, 0);
    vecs[7]  = mk(1, 2, 1, 1, 9, 9, 0, 0, 0, 9, 1, 1, 9, 1, 0, EN_RUN, FL_NONE,
                  FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0);
    vecs[8]  = mk(1, 2, 1, 1, 3, 4, 0, 0, 0, 3, 1, 0, 3, 1, 0, EN_RUN, FL_NONE, FWD ? 2'd1 : 2'd0, 0);
    vecs[9]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, EN_RUN, FL_ALL, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 6, 0, 0, 0, 6, 1, 0, 0, 0, 1, EN_RUN, FL_ALL, 0, FWD ? 2'd1 : 2'd0);
    vecs[11] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, EN_RUN, FL_NONE, 0, 0);
    vecs[12] = mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,
                  FWD ? EN_RUN : EN_STALL, FWD ? FL_NONE : FL_STALL, 0, 0);

    // reset values
    quiet();
    rst = 1'b0;
    @(negedge clk); #1;
    chk_ctl("reset held", EN_NONE, FL_ALL, 0, 0);
    @(negedge clk);
    rst = 1'b1; #1;
    chk_cnt("after reset", 0, 0, 1'b0);
    chk("after reset state", 32'(dbg_dmem_state), 32'd0);
    chk_ctl("idle", EN_RUN, FL_NONE, 0, 0);

    // single-cycle vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk_ctl($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_fl, vecs[i].exp_fa, vecs[i].exp_fb);
      if (vecs[i].exp_en == EN_STALL) exp_stall++;
      if (vecs[i].br) exp_flush++;
    end
    @(negedge clk);
    quiet(); #1;
    chk_cnt("after table", exp_stall, exp_flush, 1'b0);

`ifdef PIPELINE_FORWARDING_EN
    // load-use: one bubble, then the dependent op takes the WB value
    @(negedge clk); quiet();
    id_ex_dest_reg_idx = 5; id_ex_reg_wr = 1; id_ex_rd_mem = 1; id_rs1_idx = 5; id_rs1_used = 1;
    #1; chk_ctl("loaduse c1", EN_STALL, FL_STALL, 0, 0);
    exp_stall++;
    @(negedge clk); quiet();
    id_ex_rs1_idx = 5; mem_wb_dest_reg_idx = 5; mem_wb_reg_wr = 1;
    #1; chk_ctl("loaduse c2", EN_RUN, FL_NONE, 2, 0);
`else
    // back-to-back RAW without forwarding: three bubbles while the writer drains
    @(negedge clk); quiet();
    id_rs1_idx = 7; id_rs1_used = 1; id_ex_dest_reg_idx = 7; id_ex_reg_wr = 1;
    #1; chk_ctl("raw c1", EN_STALL, FL_STALL, 0, 0);
    @(negedge clk); quiet();
    id_rs1_idx = 7; id_rs1_used = 1; ex_mem_dest_reg_idx = 7; ex_mem_reg_wr = 1;
    #1; chk_ctl("raw c2", EN_STALL, FL_STALL, 0, 0);
    @(negedge clk); quiet();
    id_rs1_idx = 7; id_rs1_used = 1; mem_wb_dest_reg_idx = 7; mem_wb_reg_wr = 1;
    #1; chk_ctl("raw c3", EN_STALL, FL_STALL, 0, 0);
    @(negedge clk); quiet();
    id_rs1_idx = 7; id_rs1_used = 1;
    #1; chk_ctl("raw c4", EN_RUN, FL_NONE, 0, 0);
    exp_stall += 3;
`endif
    @(negedge clk); quiet(); #1;
    chk_cnt("after seq", exp_stall, exp_flush, 1'b0);

    // memory wait of 4 cycles, with a branch arriving while frozen
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      quiet();
      ex_mem_rd_mem = 1; ex_mem_reg_wr = 1; ex_mem_dest_reg_idx = 8; dmem_ready = 0;
      ex_mem_take_branch = (i >= 3);
      #1;
      chk_ctl($sformatf("freeze c%0d", i), EN_NONE, FL_NONE, 0, 0);
      chk($sformatf("freeze c%0d err", i), 32'(dmem_err), 32'(i == 4));
      chk($sformatf("freeze c%0d state", i), 32'(dbg_dmem_state), 32'(i > 1));
    end
    @(negedge clk);
    dmem_ready = 1; #1;
    chk_ctl("ready cycle", EN_RUN, FL_ALL, 0, 0);
    @(negedge clk);
    quiet(); #1;
    chk_cnt("after wait", 4, 1, 1'b1);
    chk("after wait state", 32'(dbg_dmem_state), 32'd0);
    repeat (2) @(negedge clk);
    #1; chk("err sticky", 32'(dmem_err), 32'd1);

    // reset while in WAIT aborts the access
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet(); ex_mem_wr_mem = 1; dmem_ready = 0;
    end
    #1; chk("pre-abort state", 32'(dbg_dmem_state), 32'd1);
    @(negedge clk);
    rst = 1'b0; #1;
    chk_ctl("rst in wait", EN_NONE, FL_ALL, 0, 0);
    @(negedge clk); #1;
    chk_cnt("rst in wait", 0, 0, 1'b0);
    chk("rst in wait state", 32'(dbg_dmem_state), 32'd0);
    chk_ctl("rst still held", EN_NONE, FL_ALL, 0, 0);
    @(negedge clk);
    rst = 1'b1; quiet(); #1;
    chk_ctl("post abort", EN_RUN, FL_NONE, 0, 0);
    @(negedge clk); #1;
    chk("no replay state", 32'(dbg_dmem_state), 32'd0);
    chk("no replay stall", 32'(stall_cycles), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard, stall and flush controller for the 5-stage RISC-V pipeline. It replaces the constant-1 pipeline-register enables with a sequenced scheme:
- detects RAW hazards between the ID stage and older in-flight instructions;
- squashes wrong-path instructions when a branch resolves in EX/MEM;
- freezes the whole pipeline while the data memory is not ready.

It sits beside the processor top level, reads indices and control bits from the pipeline registers, and drives every register enable and flush line, plus optional forwarding selects.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `DMEM_TIMEOUT`, default 255: maximum consecutive not-ready cycles before `dmem_err` is set.

- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-low.
- `id_rs1_idx`, `id_rs2_idx` in 5: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1: the ID instruction actually reads that source.
- `id_ex_rs1_idx`, `id_ex_rs2_idx` in 5: sources of the instruction in EX (used for forwarding).
- `id_ex_dest_reg_idx` in 5, `id_ex_reg_wr` in 1, `id_ex_rd_mem` in 1: EX destination index, register-write flag and load flag.
- `ex_mem_dest_reg_idx` in 5, `ex_mem_reg_wr` in 1, `ex_mem_rd_mem` in 1, `ex_mem_wr_mem` in 1: the same for the MEM stage, plus its store flag.
- `mem_wb_dest_reg_idx` in 5, `mem_wb_reg_wr` in 1: WB destination index and register-write flag.
- `ex_mem_take_branch` in 1: resolved taken branch/jump in MEM.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`, `mem_wb_enable` out 1: PC and pipeline-register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1: load NOOP_INST and valid=0 into that register on the next edge.
- `fwd_a_sel`, `fwd_b_sel` out 2: forwarding selects for the EX operands.
  - 0: register value.
  - 1: `ex_mem_alu_result`.
  - 2: `wb_reg_wr_data_out`.
- `stall_cycles`, `flush_events` out `CNT_W`: performance counters.
- `dmem_err` out 1: sticky memory-timeout flag.

## Operation
- **Hazard match:** a stage matches ID source *s* when all of the following hold:
  - the stage's `reg_wr` is 1;
  - its destination index is nonzero;
  - its destination index equals *s*;
  - the `used` flag for *s* is 1.
  - x0 never creates a hazard.
- **Data-hazard stall (hz):**
  - Behaviour depends on `FORWARDING_EN` (see Configuration).
  - On a stall: `pc_enable=0`, `if_id_enable=0` and `id_ex_flush=1` (a bubble is inserted). Later stages proceed.
- **Branch flush:** when `ex_mem_take_branch=1`:
  - `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are all 1;
  - `pc_enable=1` (the IF stage loads the target);
  - `flush_events` increments by 1.
- **Data-memory wait FSM, states IDLE and WAIT:**
  - IDLE → WAIT when (`ex_mem_rd_mem` or `ex_mem_wr_mem`) and `!dmem_ready`.
  - WAIT → IDLE when `dmem_ready`.
  - While the request is pending (IDLE with the entry condition true, or WAIT with `!dmem_ready`), the pipeline is frozen: every enable is 0 and every flush is 0.
  - A wait counter counts frozen cycles and clears on leaving WAIT.
  - When the wait counter reaches `DMEM_TIMEOUT`, `dmem_err` is set. It clears only on reset; the FSM keeps waiting.
- **Priority:** freeze > branch flush > hazard stall.
  - A branch that resolves while frozen is acted on in the first unfrozen cycle, because the EX/MEM register holds it.
  - A hazard coinciding with a branch flush is dropped, since the stalled instruction is squashed anyway.
- **Counters:**
  - `stall_cycles` increments on every cycle with a freeze or a hazard stall.
  - Both counters wrap modulo 2^`CNT_W`.
- **Idle state:** all enables are 1 and all flushes are 0.

## Timing
- Enables, flushes and `fwd_*` are combinational from the inputs and the FSM state, so they act on the same clock edge.
- Added latency:
  - load-use stall: 1 cycle;
  - branch penalty: 3 squashed instructions;
  - memory wait: one freeze cycle per not-ready cycle.
- **Reset (`rst`=0 at an edge):**
  - FSM enters IDLE; wait counter, `stall_cycles`, `flush_events` and `dmem_err` are all 0.
  - While `rst`=0, all enables are 0, all flushes are 1 and `fwd_*` are 0.
  - Reset mid-WAIT aborts the access; there is no replay.
- `rst` deasserted: normal operation starts on the next edge.

## Configuration
- Macro: `PIPELINE_FORWARDING_EN`.
- **Defined:**
  - A hazard stall occurs only for load-use, i.e. `id_ex_rd_mem=1` and the EX stage matches.
  - `fwd_a_sel`/`fwd_b_sel` are computed for the `id_ex_rs*` sources. Priority: EX/MEM match and not `ex_mem_rd_mem` → 1; else MEM/WB match → 2; else 0.
- **Undefined:**
  - A hazard stall occurs on any match in ID/EX, EX/MEM or MEM/WB, because the register file does not bypass.
  - `fwd_*` are tied to 0.
  - The `id_ex_rs*` inputs are unused.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - FSM state enum `dmem_state_t` (IDLE, WAIT);
  - `fwd_sel_t` constants `FWD_REG`, `FWD_EXMEM`, `FWD_WB`;
  - the shared `DMEM_TIMEOUT` default.
- One sub-module `dmem_wait_fsm`: FSM, wait counter and `dmem_err`; outputs `freeze`.
- Hazard compare, priority logic and counters stay in `pipeline_ctrl`.

## Test plan
- **Load-use:** load x5 in EX; ID reads x5 with `used`=1, forwarding on → 1 cycle with `pc_enable=0`, `id_ex_flush=1`; then `fwd_a_sel=2`; `stall_cycles`=1.
- **No-forward RAW:** forwarding off; add writes x7; next instruction reads x7 → 3 stall cycles; `fwd_*` stay 0.
- **x0 and unused source:** destination x0, or `used`=0 → no stall, no forwarding.
- **Branch flush:** `ex_mem_take_branch=1` coincident with a load-use hazard → all three flushes = 1, `pc_enable=1`, `flush_events`=1, no stall counted.
- **Memory wait:** load with `dmem_ready` low for 4 cycles → all enables 0 for 4 cycles; resumes on the ready cycle; `stall_cycles`=4. With `DMEM_TIMEOUT`=3, `dmem_err`=1 and stays set.
- **Reset mid-WAIT:** `rst`=0 during WAIT → next cycle FSM in IDLE, counters 0, `dmem_err`=0, flushes 1 while reset is held.
